pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline-stage register that replaces fixed stall-vector inter-stage registers, such as IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an opaque payload of DATA_W bits through a DEPTH-entry circular buffer using a valid/ready handshake on both sides.
- Supports a synchronous flush for branch/jump squash.
- Presents BUBBLE_VAL (the NOP encoding) downstream whenever empty.

---
 rtl/pipe_stage_buf_if.sv | 22 ++
 rtl/pipe_stage_buf.sv | 93 +++++++++
 tb/tb_pipe_stage_buf.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for one elastic pipeline stage: upstream push side
// and downstream pop side. The stage itself uses the slave modport.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 128
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register: DEPTH-entry circular FIFO with valid/ready on both
// sides, synchronous flush, and BUBBLE_VAL shown downstream when empty.
// Optional stall/bubble counters are compiled in with `define PIPE_STAGE_PERF_EN.
module pipe_stage_buf #(
    parameter int                DATA_W     = 128,
    parameter int                DEPTH      = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    localparam int               CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_buf_if.slave  bus,
    output logic [CNT_W-1:0] count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      bubble_cycles
`endif
);

    // DEPTH=1 still needs a one-bit pointer even though it never leaves 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // in_ready is a pure function of registered occupancy, so there is no
    // combinational path from out_ready back upstream.
    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? storage[rd_ptr] : BUBBLE_VAL;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_next(wr_ptr);
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Flush only rewinds the pointers; stale entries stay but can never be read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                storage[i] <= BUBBLE_VAL;
        end else if (!flush && push) begin
            storage[wr_ptr] <= bus.in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && !flush)
                stall_cycles <= sat_inc(stall_cycles);
            if (!bus.out_valid)
                bubble_cycles <= sat_inc(bubble_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=3 instance driven with
// directed vectors; monitors pop expected payloads whenever a handshake completes.
module tb_pipe_stage_buf;

    localparam int DW = 128;

    logic clk;
    logic rst;
    logic flush2;
    logic flush3;
    logic [1:0] count2;
    logic [1:0] count3;

    int n_vec;
    int n_fail;
    int max3;

    logic [DW-1:0] exp2 [$];
    logic [DW-1:0] exp3 [$];
    logic [DW-1:0] e2;
    logic [DW-1:0] e3;

    pipe_stage_buf_if #(.DATA_W(DW)) bus2 ();
    pipe_stage_buf_if #(.DATA_W(DW)) bus3 ();

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall2, bubble2, stall3, bubble3;
`endif

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(2)) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush2),
        .bus           (bus2.slave),
        .count         (count2)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles  (stall2),
        .bubble_cycles (bubble2)
`endif
    );

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(3)) u_dut3 (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush3),
        .bus           (bus3.slave),
        .count         (count3)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cycles  (stall3),
        .bubble_cycles (bubble3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [DW-1:0] v);
        logic rdy;
        bus2.in_valid = 1'b1;
        bus2.in_data  = v;
        exp2.push_back(v);
        for (int k = 0; k < 20; k++) begin
            rdy = bus2.in_ready;
            step();
            if (rdy) begin
                bus2.in_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_fail++;
        $display("FAIL push2_timeout: value %h not accepted in 20 cycles", v);
        bus2.in_valid = 1'b0;
    endtask

    task automatic push3(input logic [DW-1:0] v);
        logic rdy;
        bus3.in_valid = 1'b1;
        bus3.in_data  = v;
        exp3.push_back(v);
        for (int k = 0; k < 20; k++) begin
            rdy = bus3.in_ready;
            step();
            if (rdy) begin
                bus3.in_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_fail++;
        $display("FAIL push3_timeout: value %h not accepted in 20 cycles", v);
        bus3.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !flush2 && bus2.out_valid && bus2.out_ready) begin
            if (exp2.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL dut2_unexpected: got %h, expected no output", bus2.out_data);
            end else begin
                e2 = exp2.pop_front();
                chk("dut2_out", bus2.out_data, e2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && int'(count3) > max3)
            max3 = int'(count3);
        if (!rst && !flush3 && bus3.out_valid && bus3.out_ready) begin
            if (exp3.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL dut3_unexpected: got %h, expected no output", bus3.out_data);
            end else begin
                e3 = exp3.pop_front();
                chk("dut3_out", bus3.out_data, e3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_fail = 0;
        max3 = 0;
        rst = 1'b1;
        flush2 = 1'b0;
        flush3 = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // 1: reset state
        chk("rst_out_valid", DW'(bus2.out_valid), DW'(0));
        chk("rst_out_data", bus2.out_data, '0);
        chk("rst_in_ready", DW'(bus2.in_ready), DW'(1));
        chk("rst_count", DW'(count2), DW'(0));
        chk("rst_count3", DW'(count3), DW'(0));

        // 2: streaming at one per cycle, occupancy stays 1
        bus2.out_ready = 1'b1;
        push2(128'h11);
        chk("s2_data_11", bus2.out_data, 128'h11);
        chk("s2_count_a", DW'(count2), DW'(1));
        push2(128'h22);
        chk("s2_data_22", bus2.out_data, 128'h22);
        chk("s2_count_b", DW'(count2), DW'(1));
        push2(128'h33);
        chk("s2_data_33", bus2.out_data, 128'h33);
        chk("s2_count_c", DW'(count2), DW'(1));
        step();
        chk("s2_drained_valid", DW'(bus2.out_valid), DW'(0));
        chk("s2_drained_data", bus2.out_data, '0);

        // 3: backpressure, third push held until space opens
        bus2.out_ready = 1'b0;
        push2(128'hA);
        push2(128'hB);
        chk("s3_count_full", DW'(count2), DW'(2));
        chk("s3_in_ready_full", DW'(bus2.in_ready), DW'(0));
        bus2.in_valid = 1'b1;
        bus2.in_data  = 128'hC;
        exp2.push_back(128'hC);
        step();
        chk("s3_count_held", DW'(count2), DW'(2));
        chk("s3_head_a", bus2.out_data, 128'hA);
        bus2.out_ready = 1'b1;
        step();
        chk("s3_count_after_pop", DW'(count2), DW'(1));
        chk("s3_in_ready_open", DW'(bus2.in_ready), DW'(1));
        step();
        bus2.in_valid = 1'b0;
        chk("s3_count_push_pop", DW'(count2), DW'(1));
        chk("s3_head_c", bus2.out_data, 128'hC);
        step();
        chk("s3_count_empty", DW'(count2), DW'(0));

        // 4: DEPTH=3 pointer wrap
        bus3.out_ready = 1'b0;
        push3(128'h1);
        push3(128'h2);
        push3(128'h3);
        chk("s4_count_full", DW'(count3), DW'(3));
        chk("s4_in_ready_full", DW'(bus3.in_ready), DW'(0));
        bus3.out_ready = 1'b1;
        push3(128'h4);
        push3(128'h5);
        bus3.out_ready = 1'b0;
        push3(128'h6);
        bus3.out_ready = 1'b1;
        push3(128'h7);
        repeat (5) step();
        chk("s4_count_drained", DW'(count3), DW'(0));
        chk("s4_max_count", DW'(max3), DW'(3));

        // 5: flush with a same-cycle push on a full DEPTH=2 stage
        bus2.out_ready = 1'b0;
        push2(128'h1);
        push2(128'h2);
        chk("s5_count_full", DW'(count2), DW'(2));
        flush2 = 1'b1;
        bus2.in_valid = 1'b1;
        bus2.in_data  = 128'h55;
        step();
        flush2 = 1'b0;
        bus2.in_valid = 1'b0;
        exp2.delete();
        chk("s5_count", DW'(count2), DW'(0));
        chk("s5_out_valid", DW'(bus2.out_valid), DW'(0));
        chk("s5_out_data", bus2.out_data, '0);
        chk("s5_in_ready", DW'(bus2.in_ready), DW'(1));
        bus2.out_ready = 1'b1;
        repeat (3) step();
        push2(128'h66);
        repeat (2) step();

        // 5b: flush on DEPTH=3 with room, so the same-cycle push would have landed
        bus3.out_ready = 1'b0;
        push3(128'h101);
        push3(128'h102);
        flush3 = 1'b1;
        bus3.in_valid = 1'b1;
        bus3.in_data  = 128'h55;
        step();
        flush3 = 1'b0;
        bus3.in_valid = 1'b0;
        exp3.delete();
        chk("s5b_count", DW'(count3), DW'(0));
        chk("s5b_out_data", bus3.out_data, '0);
        bus3.out_ready = 1'b1;
        repeat (3) step();
        push3(128'h103);
        repeat (2) step();
        chk("s5b_count_end", DW'(count3), DW'(0));

`ifdef PIPE_STAGE_PERF_EN
        // 6: stall and bubble counters
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus2.out_ready = 1'b0;
        bus2.in_valid  = 1'b1;
        bus2.in_data   = 128'h77;
        exp2.push_back(128'h77);
        step();
        bus2.in_valid = 1'b0;
        repeat (5) step();
        chk("s6_stall", DW'(stall2), DW'(5));
        chk("s6_bubble_before", DW'(bubble2), DW'(1));
        bus2.out_ready = 1'b1;
        step();
        repeat (3) step();
        chk("s6_stall_hold", DW'(stall2), DW'(5));
        chk("s6_bubble_after", DW'(bubble2), DW'(4));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s6_stall_rst", DW'(stall2), DW'(0));
        chk("s6_bubble_rst", DW'(bubble2), DW'(0));
`endif

        chk("end_exp2_empty", DW'(exp2.size()), DW'(0));
        chk("end_exp3_empty", DW'(exp3.size()), DW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
